// File: rtl/alu_sequencer_if.sv
// Request handshake between an operation issuer and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_operand;

  modport master (output req_valid, output req_op, output req_operand, input req_ready);
  modport slave  (input req_valid, input req_op, input req_operand, output req_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one 8-bit op through the external ripple-carry ALU and owns
// the accumulator and C/Z/N/V flags; one op every three cycles.
module alu_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] acc,
  input  logic             acc_oe,
  output wire  [WIDTH-1:0] acc_bus,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             done
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBC  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_CMP  = 3'd7;

  logic [1:0]       state, state_d;
  logic [2:0]       op_q, op_d;
  logic             ready_d, en_d, cin_d, done_d;
  logic [WIDTH-1:0] a_d, b_d, acc_d;
  logic             c_d, z_d, n_d, v_d;

  assign acc_bus = acc_oe ? acc : {WIDTH{1'bz}};

  // Next state, ALU drive on accept, and commit of the ALU result.
  always_comb begin
    state_d = state;
    op_d    = op_q;
    ready_d = req.req_ready;
    en_d    = 1'b0;
    a_d     = '0;
    b_d     = '0;
    cin_d   = 1'b0;
    done_d  = 1'b0;
    acc_d   = acc;
    c_d     = flag_c;
    z_d     = flag_z;
    n_d     = flag_n;
    v_d     = flag_v;

    case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (req.req_valid) begin
          state_d = EXEC;
          ready_d = 1'b0;
          en_d    = 1'b1;
          op_d    = req.req_op;
          a_d     = acc;
          case (req.req_op)
            OP_LOAD: begin
              a_d = '0;
              b_d = req.req_operand;
            end
            OP_ADD:  b_d = req.req_operand;
            OP_ADC: begin
              b_d   = req.req_operand;
              cin_d = flag_c;
            end
            OP_SUB, OP_CMP: begin
              b_d   = ~req.req_operand;
              cin_d = 1'b1;
            end
            OP_SBC: begin
              b_d   = ~req.req_operand;
              cin_d = flag_c;
            end
            OP_INC:  cin_d = 1'b1;
            OP_DEC:  b_d = '1;
            default: b_d = '0;
          endcase
        end
      end
      EXEC: begin
        state_d = DONE;
        done_d  = 1'b1;
        z_d     = (alu_result == '0);
        n_d     = alu_result[MSB];
        if (op_q != OP_CMP) acc_d = alu_result;
        // LOAD keeps C and V so multi-byte carry chains survive it.
        if (op_q != OP_LOAD) begin
          c_d = alu_cout;
          v_d = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_LOAD;
      req.req_ready <= 1'b1;
      alu_en        <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_cin       <= 1'b0;
      done          <= 1'b0;
      acc           <= '0;
      flag_c        <= 1'b0;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      flag_v        <= 1'b0;
    end else begin
      state         <= state_d;
      op_q          <= op_d;
      req.req_ready <= ready_d;
      alu_en        <= en_d;
      alu_a         <= a_d;
      alu_b         <= b_d;
      alu_cin       <= cin_d;
      done          <= done_d;
      acc           <= acc_d;
      flag_c        <= c_d;
      flag_z        <= z_d;
      flag_n        <= n_d;
      flag_v        <= v_d;
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequences single 8-bit arithmetic operations through the ripple-carry ALU.
- Owns the accumulator and the flag register (C, Z, N, V).
- Accepts an opcode and operand over a valid/ready handshake, then drives the ALU a/b/carryIn/en inputs for one cycle.
- Captures the ALU result and carryOut into the accumulator and flags, then signals completion. Sits directly upstream of the ALU (feeds it) and consumes its outputs.

Parameters:
- WIDTH, 8, datapath width; must equal the ALU width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  operation request present
- req_ready  output  1  sequencer can accept a request (IDLE only)
- req_op  input  3  opcode: 0 LOAD, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 INC, 6 DEC, 7 CMP
- req_operand  input  WIDTH  operand byte
- alu_a  output  WIDTH  ALU operand a
- alu_b  output  WIDTH  ALU operand b (already inverted for subtract ops)
- alu_cin  output  1  ALU carryIn
- alu_en  output  1  ALU output enable
- alu_result  input  WIDTH  ALU out
- alu_cout  input  1  ALU carryOut
- acc  output  WIDTH  accumulator value
- acc_oe  input  1  drive accumulator onto acc_bus
- acc_bus  output  WIDTH  acc when acc_oe=1, else high-Z
- flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, signed-overflow flags
- done  output  1  one-cycle pulse: result committed

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; acc=0; all flags=0; done=0; req_ready=1; alu_en=0; alu_a=alu_b=0; alu_cin=0; acc_bus=Z unless acc_oe=1.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: req_ready=1. If req_valid=1 at a clock edge, latch req_op/req_operand and go to EXEC; otherwise stay.
  - EXEC: exactly one cycle. alu_en=1 and ALU inputs driven from the latched op. At the closing edge, commit alu_result/alu_cout and go to DONE.
  - DONE: done=1 for exactly one cycle; next state IDLE.
- Outside EXEC: alu_en=0 and alu_a/alu_b/alu_cin=0, so the ALU never drives the shared bus.
- Latency and throughput: request accepted at edge T; EXEC during cycle T..T+1; acc and flags update at edge T+1; done high during T+1..T+2; req_ready high again from edge T+2. Max one op per 3 cycles.
- Requests while not IDLE are ignored (req_ready=0); nothing is queued.
- ALU drive per op (a, b, cin):
  - LOAD: 0, opd, 0
  - ADD: acc, opd, 0
  - ADC: acc, opd, flag_c
  - SUB: acc, ~opd, 1
  - SBC: acc, ~opd, flag_c
  - INC: acc, 0x00, 1
  - DEC: acc, 0xFF, 0
  - CMP: acc, ~opd, 1
- Commit rules:
  - acc <= alu_result for all ops except CMP (acc unchanged).
  - Z = (alu_result==0). N = alu_result[WIDTH-1].
  - C = alu_cout. For SUB/SBC/CMP, C=1 means no borrow.
  - V = (alu_a[MSB]==alu_b[MSB]) && (alu_result[MSB]!=alu_a[MSB]), using the driven (post-inversion) alu_b.
  - LOAD updates Z and N only; C and V are preserved, so multi-byte ADC/SBC chains survive an interleaved LOAD.
  - INC/DEC update all four flags.
- Flag source: ADC/SBC carry-in uses flag_c as held at the start of EXEC.
- acc_bus: combinational; acc_oe is independent of FSM state.
- Reset mid-operation: asynchronous return to reset values from any state. A reset during EXEC discards the op: acc and flags are not written and no done pulse is issued.
- Wrap-around: all arithmetic is modulo 2^WIDTH. Carry beyond the MSB appears only in flag_c.

Test Plan:
- LOAD 0xF0, then ADD 0x20 -> acc=0x10, C=1, Z=0, N=0, V=0; done pulses once per op; req_ready low for 2 cycles after each accept.
- LOAD 0x05, SUB 0x05 -> acc=0x00, C=1, Z=1. Then LOAD 0x05, SUB 0x06 -> acc=0xFF, C=0, N=1.
- 16-bit add 0x01FF+0x0001: LOAD 0xFF, ADD 0x01 -> acc=0x00, C=1. Then LOAD 0x01 (C stays 1), ADC 0x00 -> acc=0x02, C=0.
- Overflow and INC/DEC: LOAD 0x7F, ADD 0x01 -> acc=0x80, V=1, N=1. LOAD 0x00, DEC -> acc=0xFF, C=0, N=1. INC -> acc=0x00, C=1, Z=1.
- CMP and bus: LOAD 0x10, CMP 0x20 -> acc=0x10 unchanged, C=0, N=1, Z=0. acc_oe=1 -> acc_bus=0x10; acc_oe=0 -> acc_bus=Z; alu_en=0 in every non-EXEC cycle.
- req_valid held high continuously -> accepts exactly every 3rd cycle. Assert rst_n=0 during EXEC -> acc=0, flags=0, no done pulse, req_ready=1 immediately.
